// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns and FSM states.
package sseg_pkg;

    // Whole segment bus dark: a..g and dp all off (active low).
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // a..g patterns, active low, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG7_0     = 7'b0000001;
    localparam logic [6:0] SEG7_1     = 7'b1001111;
    localparam logic [6:0] SEG7_2     = 7'b0010010;
    localparam logic [6:0] SEG7_3     = 7'b0000110;
    localparam logic [6:0] SEG7_4     = 7'b1001100;
    localparam logic [6:0] SEG7_5     = 7'b0100100;
    localparam logic [6:0] SEG7_6     = 7'b0100000;
    localparam logic [6:0] SEG7_7     = 7'b0001111;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0000100;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Bus between the lab datapath and the scan driver: value/strobe in, display pins out.
interface sseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [7:0]              segments;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    frame_done;

    modport master (
        output en, load, digits_bcd, dp_mask,
        input  segments, anodes, frame_done
    );

    modport slave (
        input  en, load, digits_bcd, dp_mask,
        output segments, anodes, frame_done
    );
endinterface

// File: rtl/sseg_bcd_decode.sv
// Combinational BCD -> a..g decoder, active low; codes 10..15 render blank.
import sseg_pkg::*;

module sseg_bcd_decode (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    // Table lookup; anything outside 0..9 stays dark.
    always_comb begin
        o_seg = SEG7_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG7_0;
            4'd1:    o_seg = SEG7_1;
            4'd2:    o_seg = SEG7_2;
            4'd3:    o_seg = SEG7_3;
            4'd4:    o_seg = SEG7_4;
            4'd5:    o_seg = SEG7_5;
            4'd6:    o_seg = SEG7_6;
            4'd7:    o_seg = SEG7_7;
            4'd8:    o_seg = SEG7_8;
            4'd9:    o_seg = SEG7_9;
            default: o_seg = SEG7_BLANK;
        endcase
    end
endmodule

// File: rtl/sseg_scan_driver.sv
// Round-robin scan driver for NUM_DIGITS common-anode digits on a shared segment bus.
// A one-cycle blank precedes every digit's dwell; the displayed value lives in a shadow
// register that is only refreshed at the start of a frame, so digits never tear.
// Optional build macro SSEG_LZB_EN: blank leading zeros (digit 0 always shown).
import sseg_pkg::*;

module sseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               rst_n,
    sseg_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_t                      r_state;
    logic [CW-1:0]               r_div_cnt;
    logic [IW-1:0]               r_idx;
    logic [NUM_DIGITS-1:0][3:0]  r_pending;
    logic [NUM_DIGITS-1:0]       r_pend_dp;
    logic                        r_pend_valid;
    logic [NUM_DIGITS-1:0][3:0]  r_shadow;
    logic [NUM_DIGITS-1:0]       r_shadow_dp;
    logic [7:0]                  r_segments;
    logic [NUM_DIGITS-1:0]       r_anodes;
    logic                        r_frame_done;

    state_t                      w_state_nxt;
    logic [CW-1:0]               w_cnt_nxt;
    logic [IW-1:0]               w_idx_nxt;
    logic                        w_apply;
    logic [NUM_DIGITS-1:0][3:0]  w_in_bcd;
    logic [3:0]                  w_digit;
    logic [6:0]                  w_seg7;
    logic [6:0]                  w_seg7_disp;
    logic [7:0]                  w_seg_nxt;
    logic [NUM_DIGITS-1:0]       w_an_nxt;
    logic                        w_fd_nxt;

    assign w_in_bcd = bus.digits_bcd;

    // Next state, dwell counter and digit index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_div_cnt;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (bus.en) w_state_nxt = BLANK;
            end
            BLANK: begin
                w_state_nxt = DRIVE;
                w_cnt_nxt   = '0;
            end
            DRIVE: begin
                if (r_div_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    w_state_nxt = bus.en ? BLANK : IDLE;
                end else begin
                    w_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame boundary: entering the blank slot ahead of digit 0.
    assign w_apply = (w_state_nxt == BLANK) && (w_idx_nxt == '0);

    // Outputs are computed from the next state so they register alongside it.
    assign w_digit = r_shadow[w_idx_nxt];

    sseg_bcd_decode u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg7)
    );

`ifdef SSEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    logic [NUM_DIGITS-1:0] w_lz;
    assign w_lz[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
        assign w_lz[gi] = (r_shadow[NUM_DIGITS-1:gi] == '0);
    end
    assign w_seg7_disp = w_lz[w_idx_nxt] ? SEG7_BLANK : w_seg7;
`else
    assign w_seg7_disp = w_seg7;
`endif

    assign w_seg_nxt = (w_state_nxt == DRIVE) ? {w_seg7_disp, ~r_shadow_dp[w_idx_nxt]} : SEG_BLANK;
    assign w_an_nxt  = (w_state_nxt == DRIVE) ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
    assign w_fd_nxt  = (w_state_nxt == DRIVE) && (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);

    // State, counters, pending/shadow capture and registered pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_pending    <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_segments   <= SEG_BLANK;
            r_anodes     <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_segments   <= w_seg_nxt;
            r_anodes     <= w_an_nxt;
            r_frame_done <= w_fd_nxt;
            if (bus.load) begin
                r_pending    <= w_in_bcd;
                r_pend_dp    <= bus.dp_mask;
                r_pend_valid <= 1'b1;
            end
            // A load on the apply cycle bypasses pending and lands in shadow directly.
            if (w_apply && (r_pend_valid || bus.load)) begin
                r_shadow     <= bus.load ? w_in_bcd : r_pending;
                r_shadow_dp  <= bus.load ? bus.dp_mask : r_pend_dp;
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign bus.segments   = r_segments;
    assign bus.anodes     = r_anodes;
    assign bus.frame_done = r_frame_done;

endmodule
